mult_div: RTL and testbench

Multicycle signed multiply/divide unit for the datapath. It is the consumer of the operand pair selected by the MDSrcA/MDSrcB muxes, with operand B coming from register B or memory. It runs an iterative radix-2 algorithm over 32 iterations and writes the 64-bit result into its internal Hi/Lo registers. The control unit starts an operation with a one-cycle pulse, then waits for `done` before reading `hi_out` and `lo_out` (mfhi/mflo).

---
 rtl/mult_div.sv | 177 +++++++++++++++++
 tb/tb_mult_div.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div.sv
// Multicycle signed multiply/divide unit: radix-2 Booth multiply and restoring
// divide on magnitudes, 32 iterations each, with results held in Hi/Lo.
module mult_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        mult_start,
    input  logic        div_start,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_cnt;
    logic [31:0] r_a;
    logic [64:0] r_acc;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic        r_sa;
    logic        r_sq;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;
    logic        r_div_zero;

    logic [32:0] w_booth_sum;
    logic [64:0] w_acc_nxt;
    logic [32:0] w_trial;
    logic        w_div_ge;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;

    function automatic logic [31:0] f_neg_if(input logic [31:0] v, input logic neg);
        f_neg_if = neg ? (~v + 32'd1) : v;
    endfunction

    // Next-state decision; a start is only honoured in IDLE, multiply has priority
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (mult_start) begin
                    w_state_nxt = ST_MULT;
                end else if (div_start) begin
                    w_state_nxt = ST_DIV;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MULT: begin
                if (r_cnt == 6'd31) begin
                    w_state_nxt = ST_FIN;
                end else begin
                    w_state_nxt = ST_MULT;
                end
            end
            ST_DIV: begin
                if ((r_a == 32'd0) || (r_cnt == 6'd31)) begin
                    w_state_nxt = ST_FIN;
                end else begin
                    w_state_nxt = ST_DIV;
                end
            end
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Booth step: the add is done one bit wider so a most-negative multiplicand cannot overflow
    always_comb begin
        w_booth_sum = {r_acc[64], r_acc[64:33]};
        case (r_acc[1:0])
            2'b01:   w_booth_sum = {r_acc[64], r_acc[64:33]} + {r_a[31], r_a};
            2'b10:   w_booth_sum = {r_acc[64], r_acc[64:33]} - {r_a[31], r_a};
            default: w_booth_sum = {r_acc[64], r_acc[64:33]};
        endcase
    end

    assign w_acc_nxt = {w_booth_sum, r_acc[32:1]};
    assign w_trial   = {r_rem, r_quo[31]};
    assign w_div_ge  = (w_trial >= {1'b0, r_a});

    // Restoring divide step; after a successful subtract the remainder fits in 32 bits
    always_comb begin
        w_quo_nxt = {r_quo[30:0], w_div_ge};
        if (w_div_ge) begin
            w_rem_nxt = w_trial[31:0] - r_a;
        end else begin
            w_rem_nxt = w_trial[31:0];
        end
    end

    // State, control flags and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 6'd0;
            r_a        <= 32'd0;
            r_acc      <= 65'd0;
            r_rem      <= 32'd0;
            r_quo      <= 32'd0;
            r_sa       <= 1'b0;
            r_sq       <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= (w_state_nxt == ST_FIN);
            r_div_zero <= (r_state == ST_DIV) && (r_a == 32'd0);
            case (r_state)
                ST_IDLE: begin
                    if (mult_start) begin
                        r_cnt <= 6'd0;
                        r_a   <= md_a;
                        r_acc <= {32'd0, md_b, 1'b0};
                    end else if (div_start) begin
                        r_cnt <= 6'd0;
                        r_a   <= f_neg_if(md_b, md_b[31]);
                        r_quo <= f_neg_if(md_a, md_a[31]);
                        r_rem <= 32'd0;
                        r_sa  <= md_a[31];
                        r_sq  <= md_a[31] ^ md_b[31];
                    end
                end
                ST_MULT: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        r_hi <= w_acc_nxt[64:33];
                        r_lo <= w_acc_nxt[32:1];
                    end
                end
                ST_DIV: begin
                    if (r_a != 32'd0) begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'd31) begin
                            r_hi <= f_neg_if(w_rem_nxt, r_sa);
                            r_lo <= f_neg_if(w_quo_nxt, r_sq);
                        end
                    end
                end
                ST_FIN: begin
                    r_cnt <= 6'd0;
                end
                default: begin
                    r_cnt <= 6'd0;
                end
            endcase
        end
    end

    assign hi_out   = r_hi;
    assign lo_out   = r_lo;
    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: directed cases from the test plan plus
// randomized operations checked against a plain-arithmetic reference model.
module tb_mult_div;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mult_start = 1'b0;
    logic        div_start = 1'b0;
    logic [31:0] md_a = 32'd0;
    logic [31:0] md_b = 32'd0;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mult_div dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .md_a       (md_a),
        .md_b       (md_b),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: full signed product, or truncating signed divide done in 64 bits
    task automatic ref_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                          output logic dz, output int lat);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] res;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        dz = 1'b0;
        lat = 33;
        if (is_mult) begin
            res = sa * sb;
            m_hi = res[63:32];
            m_lo = res[31:0];
        end else if (b == 32'd0) begin
            dz = 1'b1;
            lat = 2;
        end else begin
            res = sa / sb;
            m_lo = res[31:0];
            res = sa % sb;
            m_hi = res[31:0];
        end
    endtask

    // One operation: start, optional stray start mid-run, optional start in the done cycle
    task automatic do_op(input string tag, input bit ms, input bit ds,
                         input logic [31:0] a, input logic [31:0] b,
                         input int inj_cycle, input bit start_on_done);
        logic exp_dz;
        int   exp_lat;
        int   cyc;
        ref_op(ms, a, b, exp_dz, exp_lat);
        @(negedge clk);
        mult_start = ms;
        div_start  = ds;
        md_a = a;
        md_b = b;
        @(posedge clk);
        #1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        md_a = $urandom;
        md_b = $urandom;
        cyc = 1;
        chk({tag, "_busy_c1"}, {63'd0, busy}, 64'd1);
        while (!done && cyc < 60) begin
            if (cyc == inj_cycle) begin
                div_start = 1'b1;
                md_a = $urandom;
                md_b = $urandom;
            end
            @(posedge clk);
            #1;
            div_start = 1'b0;
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_hi"}, {32'd0, hi_out}, {32'd0, m_hi});
        chk({tag, "_lo"}, {32'd0, lo_out}, {32'd0, m_lo});
        chk({tag, "_divzero"}, {63'd0, div_zero}, {63'd0, exp_dz});
        if (start_on_done) begin
            mult_start = 1'b1;
            md_a = $urandom;
            md_b = $urandom;
        end
        @(posedge clk);
        #1;
        mult_start = 1'b0;
        chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        chk({tag, "_no_restart"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rm;
        int          cyc;

        #12;
        chk("rst_hi", {32'd0, hi_out}, 64'd0);
        chk("rst_lo", {32'd0, lo_out}, 64'd0);
        chk("rst_ctl", {61'd0, busy, done, div_zero}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        do_op("mul_7xm3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, 1'b0);
        chk("mul_7xm3_hi_const", {32'd0, hi_out}, 64'hFFFF_FFFF);
        chk("mul_7xm3_lo_const", {32'd0, lo_out}, 64'hFFFF_FFEB);
        do_op("div_5by0", 1'b0, 1'b1, 32'd5, 32'd0, 0, 1'b0);
        chk("div0_hold_hi", {32'd0, hi_out}, 64'hFFFF_FFFF);
        chk("div0_hold_lo", {32'd0, lo_out}, 64'hFFFF_FFEB);

        do_op("mul_maxpos", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 1'b0);
        chk("mul_maxpos_hi_const", {32'd0, hi_out}, 64'h3FFF_FFFF);
        do_op("mul_minneg", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
        chk("mul_minneg_hi_const", {32'd0, hi_out}, 64'h4000_0000);
        do_op("div_m7by2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        chk("div_m7by2_lo_const", {32'd0, lo_out}, 64'hFFFF_FFFD);
        do_op("div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        chk("div_ovf_lo_const", {32'd0, lo_out}, 64'h8000_0000);

        do_op("mul_inject", 1'b1, 1'b0, 32'd12345, 32'hFFFF_0001, 10, 1'b1);
        do_op("both_start", 1'b1, 1'b1, 32'hFFFF_FFF0, 32'd1000, 0, 1'b0);

        // Abort a divide at cycle 15 with an asynchronous reset
        @(negedge clk);
        div_start = 1'b1;
        md_a = 32'd100000;
        md_b = 32'd7;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        cyc = 1;
        while (cyc < 15) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        reset = 1'b0;
        #1;
        chk("abort_hi", {32'd0, hi_out}, 64'd0);
        chk("abort_lo", {32'd0, lo_out}, 64'd0);
        chk("abort_ctl", {61'd0, busy, done, div_zero}, 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        do_op("mul_6x7", 1'b1, 1'b0, 32'd6, 32'd7, 0, 1'b0);
        chk("mul_6x7_lo_const", {32'd0, lo_out}, 64'd42);

        for (int i = 0; i < 24; i++) begin
            rm = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = 32'($urandom_range(0, 15)) - 32'd8;
                2:       rb = 32'd0;
                default: rb = {1'b1, 31'($urandom)};
            endcase
            do_op("rand", rm, ~rm, ra, rb, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
